core_mdu_sequencer: RTL and testbench

//  Multi-cycle controller for the RV32 "M" extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/core_mdu_pkg.sv | 13 +
 rtl/core_mdu_div_step.sv | 17 +
 rtl/core_mdu_sequencer.sv | 127 ++++++++++++
 tb/tb_core_mdu_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_mdu_pkg.sv
// core_mdu_pkg: shared state/op encodings and op-class helpers for the M-extension sequencer
package core_mdu_pkg;
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} mdu_state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } mdu_op_e;
    function automatic logic is_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction
    function automatic logic is_rem(input mdu_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction
endpackage

// File: rtl/core_mdu_div_step.sv
// core_mdu_div_step: one combinational restoring-divide iteration
module core_mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);
    logic [XLEN+1:0] shifted;
    logic            ge;
    assign shifted = {rem, quo[XLEN-1]};
    assign ge      = shifted >= {2'b0, divisor};
    assign rem_nxt = (XLEN+1)'(ge ? shifted - {2'b0, divisor} : shifted);
    assign quo_nxt = {quo[XLEN-2:0], ge};
endmodule

// File: rtl/core_mdu_sequencer.sv
// core_mdu_sequencer: multi-cycle RV32M mul/div controller with busy stall and done pulse.
// Define CORE_MDU_FAST_MUL_EN for a single-cycle combinational multiply path.
module core_mdu_sequencer
    import core_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mdu_valid,
    input  logic [2:0]      i_mdu_funct3,
    input  logic [XLEN-1:0] i_mdu_rs1,
    input  logic [XLEN-1:0] i_mdu_rs2,
    input  logic            i_mdu_flush,
    output logic            o_mdu_ready,
    output logic            o_mdu_busy,
    output logic            o_mdu_done,
    output logic [XLEN-1:0] o_mdu_result
);
    localparam int CW = $clog2(XLEN);
    mdu_state_e        state, state_nxt;
    mdu_op_e           op, req_op;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, prod_s;
    logic [XLEN:0]     rem, rem_nxt;
    logic [XLEN-1:0]   opb, quo_nxt, a_in, b_in, special_res, fix_res, quo_s, rem_s;
    logic              neg_q, neg_r, a_sgn, b_sgn, accept, div_zero, div_ovf, special;

    assign req_op      = mdu_op_e'(i_mdu_funct3);
    assign a_sgn       = i_mdu_rs1[XLEN-1] & (req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign b_sgn       = i_mdu_rs2[XLEN-1] & (req_op inside {OP_MULH, OP_DIV, OP_REM});
    assign a_in        = a_sgn ? -i_mdu_rs1 : i_mdu_rs1;
    assign b_in        = b_sgn ? -i_mdu_rs2 : i_mdu_rs2;
    assign accept      = i_mdu_valid & (state == IDLE) & ~i_mdu_flush;
    assign div_zero    = is_div(req_op) & (i_mdu_rs2 == '0);
    assign div_ovf     = (req_op inside {OP_DIV, OP_REM}) & (i_mdu_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_mdu_rs2);
    assign special     = div_zero | div_ovf;
    assign special_res = div_zero ? (is_rem(req_op) ? i_mdu_rs1 : '1) : (is_rem(req_op) ? '0 : i_mdu_rs1);

`ifdef CORE_MDU_FAST_MUL_EN
    localparam mdu_state_e MUL_ENTRY = DONE;
    logic [2*XLEN-1:0] fast_abs, fast_prod;
    logic [XLEN-1:0]   fast_res;
    assign fast_abs  = (2*XLEN)'(a_in) * (2*XLEN)'(b_in);
    assign fast_prod = (a_sgn ^ b_sgn) ? -fast_abs : fast_abs;
    assign fast_res  = (req_op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    localparam mdu_state_e MUL_ENTRY = MUL;
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
`endif

    core_mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem     (rem),
        .quo     (acc[XLEN-1:0]),
        .divisor (opb),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Magnitudes are computed unsigned; sign is restored once in FIXUP.
    assign prod_s  = neg_q ? -acc : acc;
    assign quo_s   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_s   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    assign fix_res = is_div(op) ? (is_rem(op) ? rem_s : quo_s)
                   : (op == OP_MUL ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

    always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = special ? DONE : is_div(req_op) ? DIV : MUL_ENTRY;
`ifndef CORE_MDU_FAST_MUL_EN
            MUL:   if (cnt == '0) state_nxt = FIXUP;
`endif
            DIV:   if (cnt == '0) state_nxt = FIXUP;
            FIXUP: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_mdu_flush) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op           <= OP_MUL;
            cnt          <= '0;
            acc          <= '0;
            rem          <= '0;
            opb          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            o_mdu_result <= '0;
        end else begin
            if (accept) begin
                op    <= req_op;
                cnt   <= CW'(XLEN-1);
                rem   <= '0;
                opb   <= is_div(req_op) ? b_in : a_in;
                acc   <= {{XLEN{1'b0}}, is_div(req_op) ? a_in : b_in};
                neg_q <= a_sgn ^ b_sgn;
                neg_r <= a_sgn;
                if (special) o_mdu_result <= special_res;
`ifdef CORE_MDU_FAST_MUL_EN
                else if (!is_div(req_op)) o_mdu_result <= fast_res;
`endif
            end
`ifndef CORE_MDU_FAST_MUL_EN
            if (state == MUL) begin
                acc <= {mul_sum, acc[XLEN-1:1]};
                cnt <= cnt - 1'b1;
            end
`endif
            if (state == DIV) begin
                rem           <= rem_nxt;
                acc[XLEN-1:0] <= quo_nxt;
                cnt           <= cnt - 1'b1;
            end
            if (state == FIXUP && !i_mdu_flush) o_mdu_result <= fix_res;
        end
    end

    assign o_mdu_ready = state == IDLE;
    assign o_mdu_busy  = state != IDLE;
    assign o_mdu_done  = state == DONE;
endmodule

// File: tb/tb_core_mdu_sequencer.sv
// tb_core_mdu_sequencer: latency/result reference model with per-cycle compare, directed and random stimulus
module tb_core_mdu_sequencer;
`ifdef CORE_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, flush = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        o_mdu_ready, o_mdu_busy, o_mdu_done;
    logic [31:0] o_mdu_result;
    int          checks = 0, failures = 0;
    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = '0, m_pend = '0;

    core_mdu_sequencer #(.XLEN(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mdu_valid  (valid),
        .i_mdu_funct3 (f3),
        .i_mdu_rs1    (rs1),
        .i_mdu_rs2    (rs2),
        .i_mdu_flush  (flush),
        .o_mdu_ready  (o_mdu_ready),
        .o_mdu_busy   (o_mdu_busy),
        .o_mdu_done   (o_mdu_done),
        .o_mdu_result (o_mdu_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) return (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 34;
        return MUL_LAT;
    endfunction

    function automatic logic [31:0] pick();
        int r;
        r = int'($urandom % 6);
        case (r)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    // Reference: an op occupies the unit for its latency; result lands when the done cycle begins.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_res  = '0;
        end else if (!m_busy) begin
            if (valid && !flush) begin
                m_busy = 1'b1;
                m_left = lat_of(f3, rs1, rs2);
                m_pend = ref_res(f3, rs1, rs2);
                if (m_left == 1) m_res = m_pend;
            end
        end else if (flush) begin
            m_busy = 1'b0;
        end else begin
            m_left--;
            if (m_left == 1) m_res = m_pend;
            if (m_left == 0) m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", o_mdu_ready, !m_busy);
            chk("busy", o_mdu_busy, m_busy);
            chk("done", o_mdu_done, m_busy && m_left == 1);
            chk("result", o_mdu_result, m_res);
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!o_mdu_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("issue_ready", o_mdu_ready, 1);
        valid = 1'b1; f3 = f; rs1 = a; rs2 = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!o_mdu_done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
        int n;
        issue(f, a, b);
        wait_done(n);
        chk({name, "_lat"}, n, lat);
        chk({name, "_res"}, o_mdu_result, exp);
    endtask

    initial begin
        int n, dones;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_mdu_ready, 1);
        chk("rst_busy", o_mdu_busy, 0);
        chk("rst_done", o_mdu_done, 0);
        chk("rst_result", o_mdu_result, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("model_mul", ref_res(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        chk("model_mulhsu", ref_res(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
        chk("model_rem", ref_res(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
        chk("model_lat_ovf", lat_of(3'd4, 32'h80000000, 32'hFFFFFFFF), 1);

        run("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
        run("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run("divu", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        run("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34);
        run("div0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
        run("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 1);

        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", o_mdu_ready, 1);
        chk("flush_busy", o_mdu_busy, 0);
        chk("flush_result", o_mdu_result, 32'd5);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_mdu_done) dones++;
        end
        chk("flush_no_done", dones, 0);
        run("divu_after_flush", 3'd5, 32'd9, 32'd3, 32'd3, 34);

        @(negedge clk);
        valid = 1'b1; f3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_mdu_done && n < 100);
        chk("hold_lat", n, 34);
        chk("hold_res", o_mdu_result, 32'd14);
        f3 = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
        @(negedge clk);
        chk("b2b_idle_ready", o_mdu_ready, 1);
        @(negedge clk);
        chk("b2b_accepted", o_mdu_busy, 1);
        valid = 1'b0;
        wait_done(n);
        chk("b2b_lat", n, 34);
        chk("b2b_res", o_mdu_result, 32'd3);

        issue(3'd0, 32'd7, 32'hFFFFFFFD);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", o_mdu_ready, 1);
        chk("midrst_busy", o_mdu_busy, 0);
        chk("midrst_done", o_mdu_done, 0);
        chk("midrst_result", o_mdu_result, 0);

        repeat (4000) begin
            valid = ($urandom % 3) == 0;
            f3    = 3'($urandom);
            rs1   = pick();
            rs2   = pick();
            flush = ($urandom % 60) == 0;
            rst   = ($urandom % 700) == 0;
            @(negedge clk);
        end
        valid = 1'b0; rst = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("final_idle", o_mdu_ready, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
